// File: rtl/sram_port_arbiter_if.sv
// Requester-side port of the SRAM arbiter: one request/grant channel plus its
// 1-cycle read-return path. Instantiated once for inst fetch and once for data.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req;
  logic [DATA_W/8-1:0]   wen;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (output req, wen, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, wen, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one pipelined single-port SRAM between inst and data requesters.
// Optional ARB_ADDR_MAP_EN folds kseg0/kseg1 (0x8..0xB top nibble) to physical.
module sram_port_arbiter #(
  parameter int          ADDR_W       = 32,
  parameter int          DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  sram_port_arbiter_if.slave  i_port,
  sram_port_arbiter_if.slave  d_port,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_wen,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {RS_NONE, RS_INST, RS_DATA} resp_sel_e;

  resp_sel_e         resp_sel_q, resp_sel_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_gnt, d_gnt, i_rvalid, d_rvalid;
  logic [ADDR_W-1:0] win_addr;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a);
`ifdef ARB_ADDR_MAP_EN
    if (a[ADDR_W-1 -: 2] == 2'b10) map_addr = {3'b000, a[ADDR_W-4:0]};
    else                           map_addr = a;
`else
    map_addr = a;
`endif
  endfunction

  always_comb begin
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    ram_wen      = '0;
    win_addr     = '0;
    ram_wdata    = '0;
    starve_cnt_d = starve_cnt_q;
    resp_sel_d   = RS_NONE;
    // Data wins conflicts until inst has lost STARVE_LIMIT in a row.
    if (!rst) begin
      if (i_port.req && d_port.req) begin
        if (starve_cnt_q == LIM) i_gnt = 1'b1;
        else                     d_gnt = 1'b1;
      end else begin
        i_gnt = i_port.req;
        d_gnt = d_port.req;
      end
    end
    if (i_gnt) begin
      ram_wen   = i_port.wen;
      win_addr  = i_port.addr;
      ram_wdata = i_port.wdata;
    end else if (d_gnt) begin
      ram_wen   = d_port.wen;
      win_addr  = d_port.addr;
      ram_wdata = d_port.wdata;
    end
    ram_en   = i_gnt | d_gnt;
    ram_addr = map_addr(win_addr);

    if (i_gnt)
      starve_cnt_d = '0;
    else if (i_port.req && d_gnt && starve_cnt_q != LIM)
      starve_cnt_d = starve_cnt_q + 4'd1;

    if (i_gnt && i_port.wen == '0)      resp_sel_d = RS_INST;
    else if (d_gnt && d_port.wen == '0) resp_sel_d = RS_DATA;

    // A response owed across a reset edge is dropped and held words read as 0.
    i_rvalid  = !rst && resp_sel_q == RS_INST;
    d_rvalid  = !rst && resp_sel_q == RS_DATA;
    i_rdata_d = i_rvalid ? ram_rdata : i_rdata_q;
    d_rdata_d = d_rvalid ? ram_rdata : d_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_sel_q   <= RS_NONE;
      starve_cnt_q <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      resp_sel_q   <= resp_sel_d;
      starve_cnt_q <= starve_cnt_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign i_port.gnt    = i_gnt;
  assign d_port.gnt    = d_gnt;
  assign i_port.rvalid = i_rvalid;
  assign d_port.rvalid = d_rvalid;
  assign i_port.rdata  = rst ? '0 : i_rdata_d;
  assign d_port.rdata  = rst ? '0 : d_rdata_d;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed vectors with literal expectations plus a
// per-cycle reference model of arbitration, starvation and read return.
module tb_sram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) i_if();
  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) d_if();

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .i_port(i_if), .d_port(d_if),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_map(input logic [31:0] a);
`ifdef ARB_ADDR_MAP_EN
    if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a & 32'h1FFF_FFFF;
`endif
    return a;
  endfunction

  // Reference model: streak = conflicts data has won since inst last got in.
  int          m_streak = 0;
  int          m_owner  = 0;   // 0 none, 1 inst, 2 data read in flight
  logic [31:0] m_iw = '0, m_dw = '0;
  logic        e_ig, e_dg;
  logic [3:0]  e_wen;
  logic [31:0] e_addr, e_wdata;

  always @(negedge clk) begin
    if (rst) begin
      chk("i_gnt", {31'd0, i_if.gnt}, 32'd0);
      chk("d_gnt", {31'd0, d_if.gnt}, 32'd0);
      chk("ram_en", {31'd0, ram_en}, 32'd0);
      chk("i_rvalid", {31'd0, i_if.rvalid}, 32'd0);
      chk("d_rvalid", {31'd0, d_if.rvalid}, 32'd0);
      chk("i_rdata", i_if.rdata, 32'd0);
      chk("d_rdata", d_if.rdata, 32'd0);
      m_streak = 0; m_owner = 0; m_iw = '0; m_dw = '0;
    end else begin
      e_ig = i_if.req && (!d_if.req || m_streak >= 4);
      e_dg = d_if.req && !e_ig;
      e_wen = 4'h0; e_addr = '0; e_wdata = '0;
      if (e_ig)      begin e_wen = i_if.wen; e_addr = exp_map(i_if.addr); e_wdata = i_if.wdata; end
      else if (e_dg) begin e_wen = d_if.wen; e_addr = exp_map(d_if.addr); e_wdata = d_if.wdata; end
      chk("i_gnt", {31'd0, i_if.gnt}, {31'd0, e_ig});
      chk("d_gnt", {31'd0, d_if.gnt}, {31'd0, e_dg});
      chk("ram_en", {31'd0, ram_en}, {31'd0, e_ig | e_dg});
      chk("ram_wen", {28'd0, ram_wen}, {28'd0, e_wen});
      chk("ram_addr", ram_addr, e_addr);
      chk("ram_wdata", ram_wdata, e_wdata);
      chk("i_rvalid", {31'd0, i_if.rvalid}, {31'd0, m_owner == 1});
      chk("d_rvalid", {31'd0, d_if.rvalid}, {31'd0, m_owner == 2});
      if (m_owner == 1) m_iw = ram_rdata;
      if (m_owner == 2) m_dw = ram_rdata;
      chk("i_rdata", i_if.rdata, m_iw);
      chk("d_rdata", d_if.rdata, m_dw);
      if (e_ig) m_streak = 0;
      else if (i_if.req && e_dg && m_streak < 4) m_streak++;
      m_owner = (e_ig && i_if.wen == 4'h0) ? 1 : (e_dg && d_if.wen == 4'h0) ? 2 : 0;
    end
  end

  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic mid(); @(negedge clk); #1; endtask

  task automatic set_i(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd);
    i_if.req = r; i_if.wen = w; i_if.addr = a; i_if.wdata = wd;
  endtask
  task automatic set_d(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd);
    d_if.req = r; d_if.wen = w; d_if.addr = a; d_if.wdata = wd;
  endtask

`ifdef ARB_ADDR_MAP_EN
  localparam logic [31:0] EXP_BFC = 32'h1FC0_0000;
  localparam logic [31:0] EXP_800 = 32'h0000_1000;
`else
  localparam logic [31:0] EXP_BFC = 32'hBFC0_0000;
  localparam logic [31:0] EXP_800 = 32'h8000_1000;
`endif

  logic [31:0] i_pat;
  logic        i_hold, d_hold;

  initial begin
    set_i(0, 4'h0, '0, '0);
    set_d(0, 4'h0, '0, '0);
    ram_rdata = '0;
    nxt();
    set_i(1, 4'h0, 32'h40, '0);
    set_d(1, 4'h0, 32'h80, '0);
    mid();
    chk("rst_gnt", {30'd0, i_if.gnt, d_if.gnt}, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    nxt(); rst = 1'b0;
    mid();
    chk("first_d_gnt", {30'd0, i_if.gnt, d_if.gnt}, 32'd1);
    nxt(); set_i(0, 4'h0, '0, '0); set_d(0, 4'h0, '0, '0); ram_rdata = 32'hCAFE_0001;
    mid();
    chk("first_d_rdata", d_if.rdata, 32'hCAFE_0001);
    nxt(); set_i(1, 4'h0, 32'h0000_0100, '0); ram_rdata = '0;
    mid();
    chk("i_read_gnt", {31'd0, i_if.gnt}, 32'd1);
    chk("i_read_addr", ram_addr, 32'h0000_0100);
    nxt(); set_i(0, 4'h0, '0, '0); ram_rdata = 32'h1234_5678;
    mid();
    chk("i_read_rvalid", {31'd0, i_if.rvalid}, 32'd1);
    chk("i_read_rdata", i_if.rdata, 32'h1234_5678);
    nxt(); ram_rdata = 32'h0BAD_F00D;
    mid();
    chk("i_rdata_hold", i_if.rdata, 32'h1234_5678);

    nxt(); set_i(1, 4'h0, 32'h200, '0); set_d(1, 4'h0, 32'h300, '0);
    i_pat = '0;
    for (int k = 0; k < 10; k++) begin
      ram_rdata = 32'h1000_0000 + k;
      mid();
      i_pat[k] = i_if.gnt;
      nxt();
    end
    chk("conflict_pattern", i_pat, 32'h0000_0210);

    set_i(0, 4'h0, '0, '0); set_d(1, 4'b0011, 32'h400, 32'hDEAD_BEEF);
    mid();
    chk("d_write_wen", {28'd0, ram_wen}, 32'h3);
    chk("d_write_wdata", ram_wdata, 32'hDEAD_BEEF);
    nxt(); set_d(0, 4'h0, '0, '0); set_i(1, 4'h0, 32'h500, '0);
    mid();
    chk("d_write_no_rvalid", {31'd0, d_if.rvalid}, 32'd0);
    chk("i_after_write_gnt", {31'd0, i_if.gnt}, 32'd1);
    nxt(); set_i(0, 4'h0, '0, '0); ram_rdata = 32'h5555_AAAA;
    mid();
    chk("i_after_write_rdata", i_if.rdata, 32'h5555_AAAA);

    nxt(); set_d(1, 4'h0, 32'hBFC0_0000, '0);
    mid(); chk("map_bfc", ram_addr, EXP_BFC);
    nxt(); set_d(1, 4'h0, 32'h8000_1000, '0);
    mid(); chk("map_800", ram_addr, EXP_800);
    nxt(); set_d(1, 4'h0, 32'h1FC0_0000, '0);
    mid(); chk("map_1fc", ram_addr, 32'h1FC0_0000);

    nxt(); set_d(0, 4'h0, '0, '0); set_i(1, 4'h0, 32'h600, '0);
    mid(); chk("rst_mid_gnt", {31'd0, i_if.gnt}, 32'd1);
    nxt(); rst = 1'b1; set_i(0, 4'h0, '0, '0); ram_rdata = 32'h7777_7777;
    mid();
    chk("rst_mid_rvalid", {31'd0, i_if.rvalid}, 32'd0);
    chk("rst_mid_rdata", i_if.rdata, 32'd0);
    nxt(); rst = 1'b0;
    mid();
    chk("rst_cleared_rdata", i_if.rdata, 32'd0);
    chk("rst_cleared_d_rdata", d_if.rdata, 32'd0);

    i_hold = 1'b0; d_hold = 1'b0;
    for (int n = 0; n < 300; n++) begin
      nxt();
      ram_rdata = $urandom;
      if (!i_hold)
        set_i(1'($urandom_range(0, 1)), $urandom_range(0, 1) ? 4'h0 : 4'($urandom),
              $urandom, $urandom);
      if (!d_hold)
        set_d(1'($urandom_range(0, 1)), $urandom_range(0, 1) ? 4'h0 : 4'($urandom),
              $urandom, $urandom);
      mid();
      i_hold = i_if.req && !i_if.gnt;
      d_hold = d_if.req && !d_if.gnt;
    end
    nxt(); set_i(0, 4'h0, '0, '0); set_d(0, 4'h0, '0, '0);
    mid();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
